vend_coin_controller: RTL and testbench
=======================================

Name: vend_coin_controller

Overview:
- Control FSM that sits upstream of the 4-bit vending state register. It accepts coins, accumulates credit and requests a dispense. It then pays out change one coin per cycle.
- It owns its own 4-bit state register. The register is clocked on the falling edge of DCLK and cleared by DRES, and it is exported as state_code for the display and debug logic.

Parameters:
- PRICE_CENTS, 65, item price in cents; multiple of 5, range 5..155.
- TIMEOUT_CYC, 255, dispense-ack wait limit in DCLK cycles; used only with VEND_TIMEOUT_EN.

Ports:
- DCLK  input  1  system clock; all state updates on the falling edge.
- DRES  input  1  asynchronous active-low reset.
- coin_valid  input  1  coin present this cycle.
- coin_type  input  2  00=5c, 01=10c, 10=25c, 11=slug.
- cancel  input  1  refund request.
- dispense_ack  input  1  dispenser has released the item.
- dispense_req  output  1  level request to the dispenser.
- change_valid  output  1  one-cycle pulse: eject one coin.
- change_coin  output  2  coin to eject (00/01/10, same encoding as coin_type).
- coin_reject  output  1  one-cycle pulse: return the coin just inserted.
- credit  output  5  current credit in 5c units.
- state_code  output  4  current FSM state.
- fault  output  1  sticky dispense-timeout flag.

Behaviour:
- Clock and reset: one clock domain. Every register updates on the falling edge of DCLK. DRES low resets asynchronously, regardless of DCLK.
- Reset values: state_code=0000 (IDLE), credit=0, and dispense_req, change_valid, change_coin, coin_reject and fault all 0.
- Reset mid-vend or mid-change abandons the operation. Credit is lost and no change is paid.
- Registered outputs: all outputs are registered and reflect the edge on which the triggering input was sampled. Latency is 1 edge.
- Price: P = PRICE_CENTS/5, in units.
- Coin value: coin units are 1, 2 or 5.
- Coin rejection: a coin is rejected (coin_reject pulses, credit unchanged) when any of these hold:
  - coin_type=11;
  - credit + value > 31;
  - the FSM is in VEND or CHANGE.
- State IDLE (0000):
  - An accepted coin loads credit=value.
  - Next state is VEND if value>=P, else ACCUM.
  - cancel is ignored.
- State ACCUM (0001):
  - An accepted coin adds its value to credit.
  - If the new credit >= P, go to VEND on the same edge.
  - cancel goes to CHANGE. If cancel and coin_valid occur together, cancel wins and the coin is rejected.
- State VEND (0010):
  - dispense_req=1 while in this state.
  - On dispense_ack: credit -= P and dispense_req drops.
  - Next state is CHANGE if the remaining credit >0, else IDLE.
  - cancel is ignored in VEND.
- State CHANGE (0011):
  - Each edge emits one coin, always the largest that fits: 25c if credit>=5, else 10c if credit>=2, else 5c.
  - On that edge credit is reduced by the coin's value, change_valid=1 and change_coin carries the coin code.
  - When credit reaches 0, go to IDLE on the same edge, so the last pulse coincides with the IDLE entry.
- Illegal state_code values (0100..1111) go to IDLE with credit cleared.
- dispense_ack outside VEND is ignored.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- When defined, an 8-bit wait counter runs in VEND. If dispense_ack has not arrived after TIMEOUT_CYC edges:
  - dispense_req drops;
  - fault sets and stays set until reset;
  - the FSM goes to CHANGE with full credit, so the customer is refunded.
- After a timeout, later ack pulses are ignored.
- When not defined: there is no counter, VEND waits indefinitely and fault is tied to 0.

Test Plan:
- Exact-price vend with change: PRICE=65; insert 25,25,10,25 -> credit 5,10,12,17 units; VEND follows the last coin; dispense_ack -> credit 4; CHANGE emits 10c, 10c (credit 2, then 0); then IDLE with credit=0.
- Cancel refund: insert 10,5 then cancel -> CHANGE; pulses 10c then 5c; IDLE after 2 edges; dispense_req never asserted.
- Rejects:
  - slug (11) in ACCUM -> coin_reject pulse, credit unchanged;
  - any coin during VEND -> coin_reject pulse;
  - with PRICE=155 and credit 30, a 10c coin is rejected and a 5c coin is accepted, giving credit 31 and then VEND.
- Simultaneous events: coin_valid and cancel on the same edge in ACCUM -> coin rejected, state CHANGE, credit not incremented.
- Reset mid-operation: assert DRES low while DCLK is held steady in VEND with credit 17 -> immediate state_code=0, credit=0, dispense_req=0.
- Timeout (VEND_TIMEOUT_EN, TIMEOUT_CYC=4): reach VEND with credit 13 and no ack -> after 4 edges fault=1 and CHANGE refunds 25,25,10,5; a late ack is ignored; fault stays 1 until DRES.

Source files
------------

// File: rtl/vend_coin_controller.sv
// vend_coin_controller: coin-accepting vending control FSM.
//
// Accepts 5c/10c/25c coins, accumulates credit in 5c units, requests a
// dispense once credit covers the price, then pays change one coin per edge
// (largest coin that fits). All state updates on the falling edge of DCLK;
// DRES is an asynchronous active-low reset.
//
// Optional feature (macro VEND_TIMEOUT_EN): an 8-bit wait counter in VEND.
// If no dispense_ack arrives within TIMEOUT_CYC edges, the request drops,
// a sticky fault flag sets and the full credit is refunded via CHANGE.
// Without the macro VEND waits indefinitely and fault is tied low.
//
// Ports:
//   DCLK          in   clock, falling-edge active
//   DRES          in   async active-low reset
//   coin_valid    in   coin present this cycle
//   coin_type     in   00=5c 01=10c 10=25c 11=slug
//   cancel        in   refund request (honoured in ACCUM only)
//   dispense_ack  in   dispenser released the item
//   dispense_req  out  level request, high while in VEND
//   change_valid  out  one-edge pulse: eject change_coin
//   change_coin   out  coin to eject, coin_type encoding
//   coin_reject   out  one-edge pulse: return the inserted coin
//   credit        out  credit in 5c units
//   state_code    out  FSM state (0 IDLE, 1 ACCUM, 2 VEND, 3 CHANGE)
//   fault         out  sticky dispense-timeout flag
module vend_coin_controller #(
  parameter int unsigned PRICE_CENTS = 65,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       DCLK,
  input  logic       DRES,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       cancel,
  input  logic       dispense_ack,
  output logic       dispense_req,
  output logic       change_valid,
  output logic [1:0] change_coin,
  output logic       coin_reject,
  output logic [4:0] credit,
  output logic [3:0] state_code,
  output logic       fault
);

  // Elaboration-time guard on the configuration range.
  if ((PRICE_CENTS % 5) != 0 || PRICE_CENTS < 5 || PRICE_CENTS > 155 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : gen_bad_param
    $error("vend_coin_controller: parameter out of range");
  end

  localparam logic [4:0] Price = 5'(PRICE_CENTS / 5);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StAccum  = 4'd1,
    StVend   = 4'd2,
    StChange = 4'd3
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] credit_q, credit_d;
  logic       req_q, req_d;
  logic       change_valid_q, change_valid_d;
  logic [1:0] change_coin_q, change_coin_d;
  logic       coin_reject_q, coin_reject_d;

  logic [2:0] coin_val;
  logic [5:0] coin_sum;
  logic       coin_ok;

  logic [1:0] chg_code;
  logic [2:0] chg_val;
  logic [4:0] chg_left;

`ifdef VEND_TIMEOUT_EN
  localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_q, wait_d;
  logic       fault_q, fault_d;
`endif

  always_comb begin
    coin_val = 3'd0;
    unique case (coin_type)
      2'b00:   coin_val = 3'd1;
      2'b01:   coin_val = 3'd2;
      2'b10:   coin_val = 3'd5;
      default: coin_val = 3'd0;
    endcase
  end

  // 6-bit sum so an overflow past 31 units is visible before truncation.
  assign coin_sum = {1'b0, credit_q} + {3'b000, coin_val};
  assign coin_ok  = coin_valid && (coin_type != 2'b11) && (coin_sum <= 6'd31);

  // Largest change coin that fits the remaining credit.
  always_comb begin
    if (credit_q >= 5'd5) begin
      chg_code = 2'b10;
      chg_val  = 3'd5;
    end else if (credit_q >= 5'd2) begin
      chg_code = 2'b01;
      chg_val  = 3'd2;
    end else begin
      chg_code = 2'b00;
      chg_val  = 3'd1;
    end
    chg_left = credit_q - {2'b00, chg_val};
  end

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    change_valid_d = 1'b0;
    change_coin_d  = 2'b00;
    // Any presented coin is returned unless a state below accepts it.
    coin_reject_d  = coin_valid;
`ifdef VEND_TIMEOUT_EN
    fault_d        = fault_q;
`endif

    case (state_q)
      StIdle: begin
        if (coin_ok) begin
          credit_d      = coin_sum[4:0];
          coin_reject_d = 1'b0;
          state_d       = (coin_sum[4:0] >= Price) ? StVend : StAccum;
        end
      end
      StAccum: begin
        // cancel takes priority; a simultaneous coin stays rejected.
        if (cancel) begin
          state_d = StChange;
        end else if (coin_ok) begin
          credit_d      = coin_sum[4:0];
          coin_reject_d = 1'b0;
          if (coin_sum[4:0] >= Price) state_d = StVend;
        end
      end
      StVend: begin
        if (dispense_ack) begin
          credit_d = credit_q - Price;
          state_d  = (credit_q != Price) ? StChange : StIdle;
        end
`ifdef VEND_TIMEOUT_EN
        else if (wait_q == WaitLast) begin
          // Refund everything; credit is left untouched.
          fault_d = 1'b1;
          state_d = StChange;
        end
`endif
      end
      StChange: begin
        if (credit_q == 5'd0) begin
          state_d = StIdle;
        end else begin
          credit_d       = chg_left;
          change_valid_d = 1'b1;
          change_coin_d  = chg_code;
          if (chg_left == 5'd0) state_d = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        credit_d = 5'd0;
      end
    endcase

    req_d = (state_d == StVend);
  end

`ifdef VEND_TIMEOUT_EN
  // Counts edges spent in VEND; restarts on every VEND entry.
  assign wait_d = (state_q == StVend && state_d == StVend) ? wait_q + 8'd1 : 8'd0;
`endif

  always_ff @(negedge DCLK or negedge DRES) begin
    if (!DRES) begin
      state_q        <= StIdle;
      credit_q       <= 5'd0;
      req_q          <= 1'b0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 2'b00;
      coin_reject_q  <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      wait_q         <= 8'd0;
      fault_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      req_q          <= req_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      coin_reject_q  <= coin_reject_d;
`ifdef VEND_TIMEOUT_EN
      wait_q         <= wait_d;
      fault_q        <= fault_d;
`endif
    end
  end

  assign dispense_req = req_q;
  assign change_valid = change_valid_q;
  assign change_coin  = change_coin_q;
  assign coin_reject  = coin_reject_q;
  assign credit       = credit_q;
  assign state_code   = state_q;
`ifdef VEND_TIMEOUT_EN
  assign fault        = fault_q;
`else
  assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_vend_coin_controller.sv
// Self-checking bench for vend_coin_controller. Two instances: price 65c
// (13 units) and price 155c (31 units), both with TIMEOUT_CYC=4. Each step
// pushes its expected outputs to a scoreboard queue, and they are popped and
// compared 1 time unit after the falling edge that registers them.
module tb_vend_coin_controller;

  localparam logic [1:0] C5    = 2'b00;
  localparam logic [1:0] C10   = 2'b01;
  localparam logic [1:0] C25   = 2'b10;
  localparam logic [1:0] CSlug = 2'b11;

  logic dclk = 1'b1;
  logic dres = 1'b0;
  always #5 dclk = ~dclk;

  logic       a_cv, a_can, a_ack, b_cv, b_can, b_ack;
  logic [1:0] a_ct, b_ct;
  logic       a_rq, a_chv, a_rj, a_ft, b_rq, b_chv, b_rj, b_ft;
  logic [1:0] a_chc, b_chc;
  logic [4:0] a_cr, b_cr;
  logic [3:0] a_st, b_st;

  vend_coin_controller #(.PRICE_CENTS(65), .TIMEOUT_CYC(4)) u_dut_a (
    .DCLK(dclk), .DRES(dres), .coin_valid(a_cv), .coin_type(a_ct), .cancel(a_can),
    .dispense_ack(a_ack), .dispense_req(a_rq), .change_valid(a_chv), .change_coin(a_chc),
    .coin_reject(a_rj), .credit(a_cr), .state_code(a_st), .fault(a_ft)
  );

  vend_coin_controller #(.PRICE_CENTS(155), .TIMEOUT_CYC(4)) u_dut_b (
    .DCLK(dclk), .DRES(dres), .coin_valid(b_cv), .coin_type(b_ct), .cancel(b_can),
    .dispense_ack(b_ack), .dispense_req(b_rq), .change_valid(b_chv), .change_coin(b_chc),
    .coin_reject(b_rj), .credit(b_cr), .state_code(b_st), .fault(b_ft)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [4:0] cr;
    logic       rq;
    logic       chv;
    logic [1:0] chc;
    logic       rj;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_fault = 1'b0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one edge of stimulus into instance sel (other instance idles), push
  // the expected post-edge outputs, then pop and compare after the edge.
  task automatic step(input string tag, input bit sel, input logic cv, input logic [1:0] ct,
                      input logic can, input logic ack, input logic [3:0] st,
                      input logic [4:0] cr, input logic rq, input logic chv,
                      input logic [1:0] chc, input logic rj);
    exp_t       e;
    logic [3:0] g_st;
    logic [4:0] g_cr;
    logic [1:0] g_chc;
    logic       g_rq, g_chv, g_rj, g_ft;
    a_cv = sel ? 1'b0 : cv;  a_ct = sel ? 2'b00 : ct;
    a_can = sel ? 1'b0 : can; a_ack = sel ? 1'b0 : ack;
    b_cv = sel ? cv : 1'b0;  b_ct = sel ? ct : 2'b00;
    b_can = sel ? can : 1'b0; b_ack = sel ? ack : 1'b0;
    e.st = st; e.cr = cr; e.rq = rq; e.chv = chv; e.chc = chc; e.rj = rj;
    e.ft = sel ? 1'b0 : exp_fault;
    exp_q.push_back(e);
    @(negedge dclk);
    #1;
    e = exp_q.pop_front();
    if (sel) begin
      g_st = b_st; g_cr = b_cr; g_rq = b_rq; g_chv = b_chv; g_chc = b_chc;
      g_rj = b_rj; g_ft = b_ft;
    end else begin
      g_st = a_st; g_cr = a_cr; g_rq = a_rq; g_chv = a_chv; g_chc = a_chc;
      g_rj = a_rj; g_ft = a_ft;
    end
    check_eq({tag, ".state"},  8'(g_st),  8'(e.st));
    check_eq({tag, ".credit"}, 8'(g_cr),  8'(e.cr));
    check_eq({tag, ".req"},    8'(g_rq),  8'(e.rq));
    check_eq({tag, ".chg_v"},  8'(g_chv), 8'(e.chv));
    if (e.chv) check_eq({tag, ".chg_coin"}, 8'(g_chc), 8'(e.chc));
    check_eq({tag, ".reject"}, 8'(g_rj),  8'(e.rj));
    check_eq({tag, ".fault"},  8'(g_ft),  8'(e.ft));
  endtask

  task automatic check_reset_a(input string tag);
    check_eq({tag, ".state"},  8'(a_st),  8'h0);
    check_eq({tag, ".credit"}, 8'(a_cr),  8'h0);
    check_eq({tag, ".req"},    8'(a_rq),  8'h0);
    check_eq({tag, ".chg_v"},  8'(a_chv), 8'h0);
    check_eq({tag, ".chg_c"},  8'(a_chc), 8'h0);
    check_eq({tag, ".reject"}, 8'(a_rj),  8'h0);
    check_eq({tag, ".fault"},  8'(a_ft),  8'h0);
  endtask

  initial begin
    a_cv = 0; a_ct = 0; a_can = 0; a_ack = 0;
    b_cv = 0; b_ct = 0; b_can = 0; b_ack = 0;
    #1;
    check_reset_a("rst");
    check_eq("rst_b.state", 8'(b_st), 8'h0);
    @(negedge dclk);
    #1;
    dres = 1'b1;

    // Exact-price vend with change (P=13).
    step("v1", 0, 1, C25, 0, 0, 4'd1, 5'd5,  0, 0, C5,  0);
    step("v2", 0, 1, C25, 0, 0, 4'd1, 5'd10, 0, 0, C5,  0);
    step("v3", 0, 1, C10, 0, 0, 4'd1, 5'd12, 0, 0, C5,  0);
    step("v4", 0, 1, C25, 0, 0, 4'd2, 5'd17, 1, 0, C5,  0);
    step("v5", 0, 0, C5,  0, 0, 4'd2, 5'd17, 1, 0, C5,  0);
    step("vrj", 0, 1, C5, 0, 0, 4'd2, 5'd17, 1, 0, C5,  1);
    step("vack", 0, 0, C5, 0, 1, 4'd3, 5'd4, 0, 0, C5,  0);
    step("vc1", 0, 0, C5, 0, 0, 4'd3, 5'd2,  0, 1, C10, 0);
    step("vc2", 0, 0, C5, 0, 0, 4'd0, 5'd0,  0, 1, C10, 0);
    step("vidl", 0, 0, C5, 0, 0, 4'd0, 5'd0, 0, 0, C5,  0);

    // cancel in IDLE is ignored; then cancel refund from ACCUM.
    step("ican", 0, 0, C5,  1, 0, 4'd0, 5'd0, 0, 0, C5,  0);
    step("c1",   0, 1, C10, 0, 0, 4'd1, 5'd2, 0, 0, C5,  0);
    step("c2",   0, 1, C5,  0, 0, 4'd1, 5'd3, 0, 0, C5,  0);
    step("ccan", 0, 0, C5,  1, 0, 4'd3, 5'd3, 0, 0, C5,  0);
    step("cc1",  0, 0, C5,  0, 0, 4'd3, 5'd1, 0, 1, C10, 0);
    step("cc2",  0, 0, C5,  0, 0, 4'd0, 5'd0, 0, 1, C5,  0);

    // Slug rejected in ACCUM; coin+cancel together: cancel wins.
    step("s1",   0, 1, C5,    0, 0, 4'd1, 5'd1, 0, 0, C5, 0);
    step("slug", 0, 1, CSlug, 0, 0, 4'd1, 5'd1, 0, 0, C5, 1);
    step("both", 0, 1, C10,   1, 0, 4'd3, 5'd1, 0, 0, C5, 1);
    step("bc1",  0, 0, C5,    0, 0, 4'd0, 5'd0, 0, 1, C5, 0);

    // Overflow boundary at P=31.
    for (int i = 1; i <= 6; i++) begin
      step($sformatf("ov%0d", i), 1, 1, C25, 0, 0, 4'd1, 5'(i * 5), 0, 0, C5, 0);
    end
    step("ov10",  1, 1, C10, 0, 0, 4'd1, 5'd30, 0, 0, C5, 1);
    step("ov5",   1, 1, C5,  0, 0, 4'd2, 5'd31, 1, 0, C5, 0);
    step("ovack", 1, 0, C5,  0, 1, 4'd0, 5'd0,  0, 0, C5, 0);

    // Asynchronous reset while in VEND with credit 17.
    step("r1", 0, 1, C25, 0, 0, 4'd1, 5'd5,  0, 0, C5, 0);
    step("r2", 0, 1, C25, 0, 0, 4'd1, 5'd10, 0, 0, C5, 0);
    step("r3", 0, 1, C10, 0, 0, 4'd1, 5'd12, 0, 0, C5, 0);
    step("r4", 0, 1, C25, 0, 0, 4'd2, 5'd17, 1, 0, C5, 0);
    a_cv = 0;
    #2 dres = 1'b0;
    #1;
    check_reset_a("rmid");
    #2 dres = 1'b1;
    step("rpost", 0, 0, C5, 0, 0, 4'd0, 5'd0, 0, 0, C5, 0);

`ifdef VEND_TIMEOUT_EN
    // Dispense timeout after 4 edges in VEND, full refund, sticky fault.
    step("t1", 0, 1, C25, 0, 0, 4'd1, 5'd5,  0, 0, C5, 0);
    step("t2", 0, 1, C25, 0, 0, 4'd1, 5'd10, 0, 0, C5, 0);
    step("t3", 0, 1, C10, 0, 0, 4'd1, 5'd12, 0, 0, C5, 0);
    step("t4", 0, 1, C5,  0, 0, 4'd2, 5'd13, 1, 0, C5, 0);
    for (int i = 1; i <= 3; i++) begin
      step($sformatf("tw%0d", i), 0, 0, C5, 0, 0, 4'd2, 5'd13, 1, 0, C5, 0);
    end
    exp_fault = 1'b1;
    step("tout", 0, 0, C5, 0, 0, 4'd3, 5'd13, 0, 0, C5,  0);
    step("tr1",  0, 0, C5, 0, 0, 4'd3, 5'd8,  0, 1, C25, 0);
    step("tr2",  0, 0, C5, 0, 0, 4'd3, 5'd3,  0, 1, C25, 0);
    step("tr3",  0, 0, C5, 0, 1, 4'd3, 5'd1,  0, 1, C10, 0);
    step("tr4",  0, 0, C5, 0, 0, 4'd0, 5'd0,  0, 1, C5,  0);
    step("tack", 0, 0, C5, 0, 1, 4'd0, 5'd0,  0, 0, C5,  0);
    step("thld", 0, 0, C5, 0, 0, 4'd0, 5'd0,  0, 0, C5,  0);
    a_ack = 0;
    #2 dres = 1'b0;
    #1;
    exp_fault = 1'b0;
    check_reset_a("trst");
    #2 dres = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
